// File: rtl/sc_pointcontrol_if.sv
// Button inputs and display-path outputs of the point controller.
// The controller connects through the slave modport, the button source through master.
interface sc_pointcontrol_if #(
  parameter int PW = 3
);
  logic          SC_POINTCONTROL_startButton_InLow;
  logic          SC_POINTCONTROL_rightButton_InLow;
  logic          SC_POINTCONTROL_leftButton_InLow;
  logic [1:0]    SC_POINTCONTROL_shiftselection_Out;
  logic          SC_POINTCONTROL_load_OutLow;
  logic [PW-1:0] SC_POINTCONTROL_position_Out;
  logic          SC_POINTCONTROL_atLeft_Out;
  logic          SC_POINTCONTROL_atRight_Out;

  modport master (
    output SC_POINTCONTROL_startButton_InLow,
    output SC_POINTCONTROL_rightButton_InLow,
    output SC_POINTCONTROL_leftButton_InLow,
    input  SC_POINTCONTROL_shiftselection_Out,
    input  SC_POINTCONTROL_load_OutLow,
    input  SC_POINTCONTROL_position_Out,
    input  SC_POINTCONTROL_atLeft_Out,
    input  SC_POINTCONTROL_atRight_Out
  );

  modport slave (
    input  SC_POINTCONTROL_startButton_InLow,
    input  SC_POINTCONTROL_rightButton_InLow,
    input  SC_POINTCONTROL_leftButton_InLow,
    output SC_POINTCONTROL_shiftselection_Out,
    output SC_POINTCONTROL_load_OutLow,
    output SC_POINTCONTROL_position_Out,
    output SC_POINTCONTROL_atLeft_Out,
    output SC_POINTCONTROL_atRight_Out
  );
endinterface

// File: rtl/sc_pointcontrol.sv
// Cursor/point controller: turns start/left/right buttons into one-cycle shift
// commands and a load pulse, tracking a bounded position with optional wrap and auto-repeat.
//
// state  | meaning
// RESET  | held in reset, default outputs
// START  | power-up load pulse, position <- INIT_POS
// CHECK  | idle, waiting for a button
// INIT   | user reload pulse, position <- INIT_POS
// MOVE_R | one-cycle shift right command
// MOVE_L | one-cycle shift left command
// HOLD   | button still held, hold counter runs toward the next repeat
// BLOCK  | wait until every button is released
module sc_pointcontrol #(
  parameter int WIDTH         = 8,
  parameter int INIT_POS      = 0,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CW            = 32
) (
  input  logic              SC_POINTCONTROL_CLOCK_50,
  input  logic              SC_POINTCONTROL_RESET_InLow,
  sc_pointcontrol_if.slave  bus
);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] POS_INIT   = PW'(INIT_POS);
  localparam logic [PW-1:0] POS_MAX    = PW'(WIDTH - 1);
  localparam logic [CW-1:0] THR_DELAY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] THR_PERIOD = CW'(REPEAT_PERIOD);

  typedef enum logic [2:0] {
    S_RESET, S_START, S_CHECK, S_INIT, S_MOVE_R, S_MOVE_L, S_HOLD, S_BLOCK
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_left_q, dir_left_d;
  logic          rep_q, rep_d;
  logic [1:0]    shift_sel;
  logic          load_n;

  logic start_p, left_p, right_p;
  logic at_left, at_right, can_l, can_r, held_p, can_held, at_thr;
  logic [CW-1:0] thr;
  logic [PW-1:0] pos_inc, pos_dec;

  assign start_p  = ~bus.SC_POINTCONTROL_startButton_InLow;
  assign left_p   = ~bus.SC_POINTCONTROL_leftButton_InLow;
  assign right_p  = ~bus.SC_POINTCONTROL_rightButton_InLow;
  assign at_left  = (pos_q == '0);
  assign at_right = (pos_q == POS_MAX);
  assign can_l    = (WRAP != 0) || !at_left;
  assign can_r    = (WRAP != 0) || !at_right;
  assign held_p   = dir_left_q ? left_p : right_p;
  assign can_held = dir_left_q ? can_l : can_r;
  // First repeat waits the long delay, later repeats the short period.
  assign thr      = rep_q ? THR_PERIOD : THR_DELAY;
  assign at_thr   = (REPEAT_DELAY != 0) && (cnt_q == thr);
  assign pos_inc  = at_right ? '0 : pos_q + PW'(1);
  assign pos_dec  = at_left ? POS_MAX : pos_q - PW'(1);

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    rep_d      = rep_q;
    shift_sel  = 2'b11;
    load_n     = 1'b1;
    case (state_q)
      S_RESET: state_d = S_START;
      S_START: begin
        load_n  = 1'b0;
        pos_d   = POS_INIT;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        cnt_d = '0;
        if (start_p) begin
          state_d = S_INIT;
        end else if (left_p) begin
          state_d    = can_l ? S_MOVE_L : S_BLOCK;
          dir_left_d = 1'b1;
          rep_d      = 1'b0;
        end else if (right_p) begin
          state_d    = can_r ? S_MOVE_R : S_BLOCK;
          dir_left_d = 1'b0;
          rep_d      = 1'b0;
        end
      end
      S_INIT: begin
        load_n  = 1'b0;
        pos_d   = POS_INIT;
        state_d = S_BLOCK;
      end
      S_MOVE_R: begin
        shift_sel = 2'b01;
        pos_d     = pos_inc;
        cnt_d     = CW'(1);
        state_d   = S_HOLD;
      end
      S_MOVE_L: begin
        shift_sel = 2'b10;
        pos_d     = pos_dec;
        cnt_d     = CW'(1);
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        // Saturate so a long hold with repeat disabled never wraps the counter.
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        if (start_p) begin
          state_d = S_INIT;
        end else if (!held_p) begin
          state_d = S_BLOCK;
        end else if (at_thr) begin
          if (can_held) begin
            state_d = dir_left_q ? S_MOVE_L : S_MOVE_R;
            rep_d   = 1'b1;
          end else begin
            cnt_d = CW'(1);
          end
        end
      end
      S_BLOCK: begin
        cnt_d = '0;
        if (!start_p && !left_p && !right_p) state_d = S_CHECK;
      end
      default: state_d = S_CHECK;
    endcase
  end

  always_ff @(posedge SC_POINTCONTROL_CLOCK_50) begin
    if (!SC_POINTCONTROL_RESET_InLow) begin
      state_q    <= S_RESET;
      pos_q      <= POS_INIT;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      rep_q      <= rep_d;
    end
  end

  assign bus.SC_POINTCONTROL_shiftselection_Out = shift_sel;
  assign bus.SC_POINTCONTROL_load_OutLow        = load_n;
  assign bus.SC_POINTCONTROL_position_Out       = pos_q;
  assign bus.SC_POINTCONTROL_atLeft_Out         = at_left;
  assign bus.SC_POINTCONTROL_atRight_Out        = at_right;
endmodule

// File: tb/tb_sc_pointcontrol.sv
// Bench for sc_pointcontrol: three configurations share one button stream; an event
// model predicts every command and a negedge monitor matches the DUT against it.
module tb_sc_pointcontrol;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic start_n = 1'b1;
  logic left_n  = 1'b1;
  logic right_n = 1'b1;

  sc_pointcontrol_if #(.PW(3)) bus0 ();
  sc_pointcontrol_if #(.PW(3)) bus1 ();
  sc_pointcontrol_if #(.PW(3)) bus2 ();

  assign bus0.SC_POINTCONTROL_startButton_InLow = start_n;
  assign bus0.SC_POINTCONTROL_leftButton_InLow  = left_n;
  assign bus0.SC_POINTCONTROL_rightButton_InLow = right_n;
  assign bus1.SC_POINTCONTROL_startButton_InLow = start_n;
  assign bus1.SC_POINTCONTROL_leftButton_InLow  = left_n;
  assign bus1.SC_POINTCONTROL_rightButton_InLow = right_n;
  assign bus2.SC_POINTCONTROL_startButton_InLow = start_n;
  assign bus2.SC_POINTCONTROL_leftButton_InLow  = left_n;
  assign bus2.SC_POINTCONTROL_rightButton_InLow = right_n;

  sc_pointcontrol #(.WIDTH(W), .INIT_POS(0), .WRAP(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .CW(8)) dut0 (
    .SC_POINTCONTROL_CLOCK_50(clk), .SC_POINTCONTROL_RESET_InLow(rst_n), .bus(bus0));
  sc_pointcontrol #(.WIDTH(W), .INIT_POS(0), .WRAP(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .CW(8)) dut1 (
    .SC_POINTCONTROL_CLOCK_50(clk), .SC_POINTCONTROL_RESET_InLow(rst_n), .bus(bus1));
  sc_pointcontrol #(.WIDTH(W), .INIT_POS(2), .WRAP(0), .REPEAT_DELAY(0), .REPEAT_PERIOD(1), .CW(8)) dut2 (
    .SC_POINTCONTROL_CLOCK_50(clk), .SC_POINTCONTROL_RESET_InLow(rst_n), .bus(bus2));

  logic [1:0] sh [3];
  logic       ld [3];
  logic [2:0] ps [3];
  logic       al [3];
  logic       ar [3];
  assign sh[0] = bus0.SC_POINTCONTROL_shiftselection_Out;
  assign sh[1] = bus1.SC_POINTCONTROL_shiftselection_Out;
  assign sh[2] = bus2.SC_POINTCONTROL_shiftselection_Out;
  assign ld[0] = bus0.SC_POINTCONTROL_load_OutLow;
  assign ld[1] = bus1.SC_POINTCONTROL_load_OutLow;
  assign ld[2] = bus2.SC_POINTCONTROL_load_OutLow;
  assign ps[0] = bus0.SC_POINTCONTROL_position_Out;
  assign ps[1] = bus1.SC_POINTCONTROL_position_Out;
  assign ps[2] = bus2.SC_POINTCONTROL_position_Out;
  assign al[0] = bus0.SC_POINTCONTROL_atLeft_Out;
  assign al[1] = bus1.SC_POINTCONTROL_atLeft_Out;
  assign al[2] = bus2.SC_POINTCONTROL_atLeft_Out;
  assign ar[0] = bus0.SC_POINTCONTROL_atRight_Out;
  assign ar[1] = bus1.SC_POINTCONTROL_atRight_Out;
  assign ar[2] = bus2.SC_POINTCONTROL_atRight_Out;

  // kind: 0 = load pulse, 1 = shift right (01), 2 = shift left (10)
  typedef struct {
    int stamp;
    int kind;
    int pos;
  } ev_t;

  ev_t evq [3][$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  // Per-configuration model parameters.
  function automatic int p_wrap(int i);   return (i == 1) ? 1 : 0; endfunction
  function automatic int p_delay(int i);  return (i == 2) ? 0 : 4; endfunction
  function automatic int p_period(int i); return (i == 2) ? 1 : 2; endfunction
  function automatic int p_init(int i);   return (i == 2) ? 2 : 0; endfunction

  // Model: position, which button is being held after a move (0 none, 1 right, 2 left),
  // whether we wait for all buttons released, the first edge at which buttons matter
  // again, and the absolute edge of the next auto-repeat (-1 = none).
  int pos_m  [3];
  int held_m [3];
  int avail_m[3];
  int nrep_m [3];
  bit wait_m [3];
  bit boot_m [3];

  function automatic bit allowed(int i, int dir);
    if (p_wrap(i) != 0) return 1'b1;
    return (dir == 1) ? (pos_m[i] != W - 1) : (pos_m[i] != 0);
  endfunction

  task automatic do_move(int i, int dir, int k, int gap);
    ev_t e;
    e.stamp = k; e.kind = dir; e.pos = pos_m[i];
    evq[i].push_back(e);
    if (dir == 1) pos_m[i] = (pos_m[i] + 1) % W;
    else          pos_m[i] = (pos_m[i] + W - 1) % W;
    held_m[i]  = dir;
    avail_m[i] = k + 2;
    nrep_m[i]  = (p_delay(i) == 0) ? -1 : k + gap + 1;
  endtask

  task automatic do_load(int i, int k);
    ev_t e;
    e.stamp = k; e.kind = 0; e.pos = pos_m[i];
    evq[i].push_back(e);
    pos_m[i]   = p_init(i);
    held_m[i]  = 0;
    wait_m[i]  = 1'b1;
    avail_m[i] = k + 1;
  endtask

  task automatic model_edge(int i, bit rst, bit s, bit l, bit r);
    int k;
    k = cyc;
    if (rst) begin
      pos_m[i] = p_init(i); held_m[i] = 0; wait_m[i] = 1'b0; boot_m[i] = 1'b1;
      return;
    end
    if (boot_m[i]) begin
      ev_t e;
      e.stamp = k; e.kind = 0; e.pos = pos_m[i];
      evq[i].push_back(e);
      boot_m[i] = 1'b0; avail_m[i] = k + 1;
      return;
    end
    if (k < avail_m[i]) return;
    if (held_m[i] != 0) begin
      if (s) do_load(i, k);
      else if (!((held_m[i] == 1) ? r : l)) begin
        held_m[i] = 0; wait_m[i] = 1'b1; avail_m[i] = k + 1;
      end else if (k == nrep_m[i]) begin
        if (allowed(i, held_m[i])) do_move(i, held_m[i], k, p_period(i));
        else nrep_m[i] = -1;
      end
    end else if (wait_m[i]) begin
      if (!s && !l && !r) begin
        wait_m[i] = 1'b0; avail_m[i] = k + 1;
      end
    end else begin
      if (s) do_load(i, k);
      else if (l || r) begin
        if (allowed(i, l ? 2 : 1)) do_move(i, l ? 2 : 1, k, p_delay(i));
        else begin
          wait_m[i] = 1'b1; avail_m[i] = k + 1;
        end
      end
    end
  endtask

  task automatic mon_check(int i);
    ev_t e;
    bit cmd;
    logic [1:0] exp_sh;
    logic exp_ld;
    cmd = (sh[i] != 2'b11) || (ld[i] == 1'b0);
    if (evq[i].size() > 0 && evq[i][0].stamp < cyc) begin
      e = evq[i].pop_front();
      checks++; errors++;
      $display("FAIL missed_cmd inst%0d: nothing seen at cycle %0d, required kind %0d", i, e.stamp, e.kind);
    end
    if (cmd) begin
      checks++;
      if (evq[i].size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd inst%0d cycle %0d: shift=%b load=%b, required shift=11 load=1",
                 i, cyc, sh[i], ld[i]);
      end else begin
        e = evq[i].pop_front();
        exp_sh = (e.kind == 0) ? 2'b11 : 2'(e.kind);
        exp_ld = (e.kind == 0) ? 1'b0 : 1'b1;
        if (e.stamp != cyc || sh[i] != exp_sh || ld[i] != exp_ld || (e.kind != 0 && int'(ps[i]) != e.pos)) begin
          errors++;
          $display("FAIL cmd inst%0d: cycle %0d shift=%b load=%b pos=%0d, required cycle %0d shift=%b load=%b pos=%0d",
                   i, cyc, sh[i], ld[i], ps[i], e.stamp, exp_sh, exp_ld, e.pos);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon_check(i);
  end

  task automatic tick(bit rst, bit s, bit l, bit r);
    rst_n = !rst; start_n = !s; left_n = !l; right_n = !r;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) model_edge(i, rst, s, l, r);
    @(negedge clk);
  endtask

  task automatic hold(int n, bit rst, bit s, bit l, bit r);
    for (int j = 0; j < n; j++) tick(rst, s, l, r);
  endtask

  task automatic check_pos(string tag);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (int'(ps[i]) != pos_m[i] || al[i] != (pos_m[i] == 0) || ar[i] != (pos_m[i] == W - 1)) begin
        errors++;
        $display("FAIL %s inst%0d: pos=%0d atL=%b atR=%b, required pos=%0d atL=%b atR=%b", tag, i,
                 ps[i], al[i], ar[i], pos_m[i], (pos_m[i] == 0), (pos_m[i] == W - 1));
      end
    end
  endtask

  task automatic check_reset_outputs(string tag);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sh[i] != 2'b11 || ld[i] != 1'b1 || int'(ps[i]) != p_init(i)) begin
        errors++;
        $display("FAIL %s inst%0d: shift=%b load=%b pos=%0d, required shift=11 load=1 pos=%0d",
                 tag, i, sh[i], ld[i], ps[i], p_init(i));
      end
    end
  endtask

  task automatic do_reset();
    hold(2, 1, 0, 0, 0);
    hold(4, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pos_m[i] = p_init(i); held_m[i] = 0; avail_m[i] = 0;
      nrep_m[i] = -1; wait_m[i] = 1'b0; boot_m[i] = 1'b1;
    end

    // Reset and start-up load pulse
    hold(3, 1, 0, 0, 0);
    check_reset_outputs("reset_outputs");
    check_pos("reset_pos");
    hold(4, 0, 0, 0, 0);
    check_pos("after_start");

    // Long single right press; repeat-disabled instance moves once
    hold(20, 0, 0, 0, 1);
    hold(4, 0, 0, 0, 0);
    check_pos("long_right");

    // Auto-repeat schedule from position 0
    do_reset();
    hold(16, 0, 0, 0, 1);
    hold(4, 0, 0, 0, 0);
    check_pos("repeat_16");

    // Walk to the right edge, then press once more: block vs wrap
    do_reset();
    for (int n = 0; n < 7; n++) begin
      hold(2, 0, 0, 0, 1);
      hold(2, 0, 0, 0, 0);
    end
    check_pos("at_right_edge");
    hold(2, 0, 0, 0, 1);
    hold(3, 0, 0, 0, 0);
    check_pos("edge_block_wrap");

    // Simultaneous left+right, then start while holding left
    do_reset();
    for (int n = 0; n < 3; n++) begin
      hold(2, 0, 0, 0, 1);
      hold(2, 0, 0, 0, 0);
    end
    check_pos("at_pos3");
    hold(2, 0, 0, 1, 1);
    hold(3, 0, 0, 0, 0);
    check_pos("left_wins");
    hold(3, 0, 0, 1, 0);
    hold(2, 0, 1, 1, 0);
    hold(4, 0, 0, 1, 0);
    hold(3, 0, 0, 0, 0);
    check_pos("start_over_left");

    // Reset in the middle of an auto-repeat
    do_reset();
    hold(9, 0, 0, 0, 1);
    tick(1, 0, 0, 1);
    check_reset_outputs("reset_mid_hold");
    tick(1, 0, 0, 1);
    hold(12, 0, 0, 0, 0);
    check_pos("after_mid_reset");

    // Randomized button bursts
    for (int b = 0; b < 200; b++) begin
      bit s, l, r;
      int len;
      if ($urandom_range(0, 29) == 0) begin
        hold(int'($urandom_range(1, 3)), 1, 0, 0, 0);
      end else begin
        s   = ($urandom_range(0, 9) == 0);
        l   = ($urandom_range(0, 2) == 0);
        r   = ($urandom_range(0, 2) == 0);
        len = int'($urandom_range(1, 14));
        hold(len, 0, s, l, r);
      end
      hold(3, 0, 0, 0, 0);
      check_pos("random_burst");
    end

    hold(5, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (evq[i].size() != 0) begin
        errors++;
        $display("FAIL drain inst%0d: %0d commands never seen, required 0", i, evq[i].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
